rtype_core: RTL and testbench

//  Parametrised multicycle RV32 R-type execution core; successor to the single-slot dut stub.
//  - Owns an NREGS x XLEN register file.
//  - Fetches from an external code memory over a req/valid handshake.
//  - Executes R-type ALU ops and parks in S_BREAK on HALT or an illegal instruction.
//  - Debug port lets benches preload/inspect registers without force.

---
 rtl/rtype_core_pkg.sv | 98 +++++++++
 rtl/rtype_core_alu.sv | 49 ++++
 rtl/rtype_core.sv | 127 ++++++++++++
 tb/tb_rtype_core.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtype_core_pkg.sv
// Shared instruction format, FSM states, ALU ops and R-type decode for rtype_core.
// RTYPE_CORE_MEXT_EN adds the MUL/MULH/MULHSU/MULHU decodes.
package rtype_core_pkg;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_t;

  typedef logic [6:0] opcode_mask_t;

  localparam opcode_mask_t OPC_RTYPE = 7'b0110011;
  localparam logic [31:0]  HALT      = 32'h0010_0073;
  localparam logic [6:0]   F7_BASE   = 7'b0000000;
  localparam logic [6:0]   F7_ALT    = 7'b0100000;
  localparam logic [6:0]   F7_MEXT   = 7'b0000001;

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_WAIT   = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_WB     = 3'b100,
    S_BREAK  = 3'b110
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
  } alu_op_t;

  typedef struct packed {
    logic    legal;
    alu_op_t op;
  } decode_t;

  function automatic instruction_t encode_rtype(input logic [6:0] funct7,
                                                input logic [2:0] funct3,
                                                input logic [4:0] rd,
                                                input logic [4:0] rs1,
                                                input logic [4:0] rs2);
    instruction_t i;
    i.funct7 = funct7;
    i.rs2    = rs2;
    i.rs1    = rs1;
    i.funct3 = funct3;
    i.rd     = rd;
    i.opcode = OPC_RTYPE;
    return i;
  endfunction

  // Opcode/funct legality only; register-index range is checked by the core.
  function automatic decode_t decode_rtype(input instruction_t i);
    decode_t d;
    d.legal = (i.opcode == OPC_RTYPE);
    d.op    = ALU_ADD;
    case (i.funct7)
      F7_BASE: begin
        case (i.funct3)
          3'd0: d.op = ALU_ADD;
          3'd1: d.op = ALU_SLL;
          3'd2: d.op = ALU_SLT;
          3'd3: d.op = ALU_SLTU;
          3'd4: d.op = ALU_XOR;
          3'd5: d.op = ALU_SRL;
          3'd6: d.op = ALU_OR;
          default: d.op = ALU_AND;
        endcase
      end
      F7_ALT: begin
        case (i.funct3)
          3'd0:    d.op = ALU_SUB;
          3'd5:    d.op = ALU_SRA;
          default: d.legal = 1'b0;
        endcase
      end
`ifdef RTYPE_CORE_MEXT_EN
      F7_MEXT: begin
        case (i.funct3)
          3'd0:    d.op = ALU_MUL;
          3'd1:    d.op = ALU_MULH;
          3'd2:    d.op = ALU_MULHSU;
          3'd3:    d.op = ALU_MULHU;
          default: d.legal = 1'b0;
        endcase
      end
`endif
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rtype_core_alu.sv
// Combinational R-type ALU; multiply ops only exist when RTYPE_CORE_MEXT_EN is defined.
module rtype_alu
  import rtype_core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int unsigned SW = $clog2(XLEN);

  logic [SW-1:0] sh;
  assign sh = b[SW-1:0];

`ifdef RTYPE_CORE_MEXT_EN
  // Low 2*XLEN bits of a wrapping product equal the signed product of the extended operands.
  logic [2*XLEN-1:0] p_ss, p_su, p_uu;
  assign p_ss = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
  assign p_su = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{1'b0}}, b};
  assign p_uu = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
`endif

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_AND:    y = a & b;
      ALU_OR:     y = a | b;
      ALU_XOR:    y = a ^ b;
      ALU_SLL:    y = a << sh;
      ALU_SRL:    y = a >> sh;
      ALU_SRA:    y = $signed(a) >>> sh;
      ALU_SLT:    y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:   y = {{(XLEN-1){1'b0}}, a < b};
`ifdef RTYPE_CORE_MEXT_EN
      ALU_MUL:    y = p_uu[XLEN-1:0];
      ALU_MULH:   y = p_ss[2*XLEN-1:XLEN];
      ALU_MULHSU: y = p_su[2*XLEN-1:XLEN];
      ALU_MULHU:  y = p_uu[2*XLEN-1:XLEN];
`endif
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/rtype_core.sv
// Multicycle RV32 R-type core: register file, decode and fetch/execute FSM.
// Build with RTYPE_CORE_MEXT_EN to accept the M-extension multiply encodings.
module rtype_core
  import rtype_core_pkg::*;
#(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    NREGS    = 32,
  parameter int unsigned    PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic                     imem_valid,
  input  logic [31:0]              imem_rdata,
  input  logic                     dbg_we,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  input  logic [XLEN-1:0]          dbg_wdata,
  output logic [XLEN-1:0]          dbg_rdata,
  output logic [2:0]               state,
  output logic                     halted,
  output logic                     illegal,
  output logic [31:0]              retired
);

  localparam int unsigned AW = $clog2(NREGS);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc;
  instruction_t    ir;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] op_a, op_b, result, alu_y, rs1_val, rs2_val;
  alu_op_t         alu_op;
  decode_t         dec;
  logic            is_halt, dec_ok;

  function automatic logic idx_ok(input logic [4:0] r);
    return 32'(r) < NREGS;
  endfunction

  assign dec     = decode_rtype(ir);
  assign is_halt = (ir == HALT);
  assign dec_ok  = dec.legal && idx_ok(ir.rd) && idx_ok(ir.rs1) && idx_ok(ir.rs2);
  assign rs1_val = (ir.rs1 == 5'd0) ? '0 : regs[ir.rs1[AW-1:0]];
  assign rs2_val = (ir.rs2 == 5'd0) ? '0 : regs[ir.rs2[AW-1:0]];

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc;
  assign dbg_rdata = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  assign state     = state_q;
  assign halted    = (state_q == S_BREAK);

  rtype_alu #(.XLEN(XLEN)) u_alu (
    .op (alu_op),
    .a  (op_a),
    .b  (op_b),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_BREAK;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BREAK:  if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_WAIT;
      S_WAIT:   if (imem_valid) state_d = S_DECODE;
      S_DECODE: state_d = (is_halt || !dec_ok) ? S_BREAK : S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_BREAK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      op_a    <= '0;
      op_b    <= '0;
      alu_op  <= ALU_ADD;
      result  <= '0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      case (state_q)
        S_BREAK: if (run) begin
          pc      <= RESET_PC;
          illegal <= 1'b0;
        end
        S_WAIT: if (imem_valid) ir <= instruction_t'(imem_rdata);
        S_DECODE: if (!is_halt) begin
          if (!dec_ok) begin
            illegal <= 1'b1;
          end else begin
            op_a   <= rs1_val;
            op_b   <= rs2_val;
            alu_op <= dec.op;
          end
        end
        S_EXEC: result <= alu_y;
        S_WB: begin
          pc      <= pc + PC_W'(1);
          retired <= retired + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // Debug writes and writeback are in disjoint states, so one write port suffices.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state_q == S_BREAK && dbg_we && dbg_addr != '0) begin
      regs[dbg_addr] <= dbg_wdata;
    end else if (state_q == S_WB && ir.rd != 5'd0) begin
      regs[ir.rd[AW-1:0]] <= result;
    end
  end

endmodule

// File: tb/tb_rtype_core.sv
// Randomised self-checking bench for rtype_core against an instruction-level reference model.
module tb_rtype_core;
  import rtype_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst, run, imem_req, imem_valid, dbg_we, halted, illegal;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata, dbg_wdata, dbg_rdata, retired;
  logic [4:0]  dbg_addr;
  logic [2:0]  state;

  always #5 clk = ~clk;

  rtype_core #(.XLEN(32), .NREGS(32), .PC_W(16), .RESET_PC(16'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_rdata  (dbg_rdata),
    .state      (state),
    .halted     (halted),
    .illegal    (illegal),
    .retired    (retired)
  );

  logic [31:0] mem [256];
  int unsigned mem_delay = 1;
  logic [15:0] resp_addr;

  logic [31:0] m_regs [32];
  logic [15:0] m_pc;
  logic [31:0] m_retired;
  logic        m_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] op_f7 [$];
  logic [2:0] op_f3 [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: strobe imem_valid mem_delay cycles after a request.
  initial begin
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        resp_addr = imem_addr;
        repeat (mem_delay) @(negedge clk);
        imem_valid = 1'b1;
        imem_rdata = mem[resp_addr[7:0]];
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = '0;
      end
    end
  end

  function automatic logic ref_exec(input logic [31:0] ins, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] y);
    logic [6:0] f7;
    logic [2:0] f3;
    int unsigned sh;
    longint sa, sb, p;
    longint unsigned ua, ub, pu;
    f7 = ins[31:25];
    f3 = ins[14:12];
    sh = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    y  = '0;
    if (ins[6:0] != 7'h33) return 1'b0;
    if (f7 == 7'h00) begin
      case (f3)
        3'd0: y = a + b;
        3'd1: y = a << sh;
        3'd2: y = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: y = (a < b) ? 32'd1 : 32'd0;
        3'd4: y = a ^ b;
        3'd5: y = a >> sh;
        3'd6: y = a | b;
        default: y = a & b;
      endcase
      return 1'b1;
    end
    if (f7 == 7'h20) begin
      if (f3 == 3'd0) begin y = a - b; return 1'b1; end
      if (f3 == 3'd5) begin p = sa >>> sh; y = p[31:0]; return 1'b1; end
      return 1'b0;
    end
`ifdef RTYPE_CORE_MEXT_EN
    if (f7 == 7'h01) begin
      case (f3)
        3'd0: begin pu = ua * ub; y = pu[31:0]; return 1'b1; end
        3'd1: begin p = sa * sb; y = p[63:32]; return 1'b1; end
        3'd2: begin p = sa * longint'(ub); y = p[63:32]; return 1'b1; end
        3'd3: begin pu = ua * ub; y = pu[63:32]; return 1'b1; end
        default: return 1'b0;
      endcase
    end
`endif
    return 1'b0;
  endfunction

  task automatic model_run();
    logic [31:0] ins, y;
    logic ok;
    m_pc = 16'd0;
    m_illegal = 1'b0;
    for (int k = 0; k < 256; k++) begin
      ins = mem[m_pc[7:0]];
      if (ins == HALT) break;
      ok = ref_exec(ins, m_regs[ins[19:15]], m_regs[ins[24:20]], y);
      if (!ok) begin m_illegal = 1'b1; break; end
      if (ins[11:7] != 5'd0) m_regs[ins[11:7]] = y;
      m_pc++;
      m_retired++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = 16'd0;
    m_retired = '0;
    m_illegal = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic dbg_write(input int idx, input logic [31:0] val);
    @(negedge clk);
    dbg_we = 1'b1;
    dbg_addr = 5'(idx);
    dbg_wdata = val;
    @(negedge clk);
    dbg_we = 1'b0;
    if (idx != 0) m_regs[idx] = val;
  endtask

  task automatic rd_reg(input int idx, output logic [31:0] val);
    dbg_addr = 5'(idx);
    #1;
    val = dbg_rdata;
  endtask

  task automatic start_run();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    for (int c = 0; c < 5000 && !halted; c++) @(negedge clk);
    if (!halted) check({tag, "_timeout"}, 32'(halted), 32'd1);
    model_run();
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      rd_reg(i, v);
      check($sformatf("%s_x%0d", tag, i), v, m_regs[i]);
    end
    check({tag, "_halted"}, 32'(halted), 32'd1);
    check({tag, "_illegal"}, 32'(illegal), 32'(m_illegal));
    check({tag, "_retired"}, retired, m_retired);
    check({tag, "_pc"}, 32'(imem_addr), 32'(m_pc));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = HALT;
  endtask

  initial begin
    logic [31:0] v;
    int len, pick;

    op_f7 = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h20};
    op_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd5};
`ifdef RTYPE_CORE_MEXT_EN
    for (int i = 0; i < 4; i++) begin op_f7.push_back(7'h01); op_f3.push_back(3'(i)); end
`endif

    rst = 1'b0; run = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    clear_mem();
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    check("rst_state", 32'(state), 32'(S_BREAK));
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    compare_all("rst");

    // ADD x1,x2,x3 then HALT
    dbg_write(2, 32'd10);
    dbg_write(3, 32'd20);
    mem[0] = encode_rtype(7'h00, 3'd0, 5'd1, 5'd2, 5'd3);
    start_run();
    finish_run("add");
    rd_reg(1, v);
    check("add_x1", v, 32'd30);
    check("add_retired", retired, 32'd1);
    check("add_pc", 32'(imem_addr), 32'd1);
    compare_all("add");

    // SUB / SLT / SLTU / SRA
    clear_mem();
    dbg_write(1, 32'd32);
    dbg_write(2, 32'd76);
    dbg_write(7, 32'h8000_0000);
    dbg_write(8, 32'd4);
    mem[0] = encode_rtype(7'h20, 3'd0, 5'd3, 5'd1, 5'd2);
    mem[1] = encode_rtype(7'h00, 3'd2, 5'd4, 5'd3, 5'd1);
    mem[2] = encode_rtype(7'h00, 3'd3, 5'd5, 5'd3, 5'd1);
    mem[3] = encode_rtype(7'h20, 3'd5, 5'd6, 5'd7, 5'd8);
    start_run();
    finish_run("alu");
    rd_reg(3, v); check("sub_x3", v, 32'hFFFF_FFD4);
    rd_reg(4, v); check("slt_x4", v, 32'd1);
    rd_reg(5, v); check("sltu_x5", v, 32'd0);
    rd_reg(6, v); check("sra_x6", v, 32'hF800_0000);
    compare_all("alu");

    // Writes to x0 are dropped from both ports
    clear_mem();
    dbg_write(2, 32'd10);
    dbg_write(3, 32'd20);
    dbg_write(0, 32'hDEAD_BEEF);
    mem[0] = encode_rtype(7'h00, 3'd0, 5'd0, 5'd2, 5'd3);
    start_run();
    finish_run("x0");
    rd_reg(0, v); check("x0_zero", v, 32'd0);
    compare_all("x0");

    // Illegal ADDI, then a clean run clears the sticky flag
    do_reset();
    clear_mem();
    dbg_write(5, 32'h1234_5678);
    mem[0] = 32'h0000_0013;
    start_run();
    finish_run("addi");
    check("addi_illegal", 32'(illegal), 32'd1);
    check("addi_retired", retired, 32'd0);
    compare_all("addi");
    mem[0] = HALT;
    start_run();
    finish_run("clr");
    check("clr_illegal", 32'(illegal), 32'd0);

    // M-extension encodings
    clear_mem();
    dbg_write(9, 32'd7);
    dbg_write(10, 32'hFFFF_FFFD);
    dbg_write(11, 32'hFFFF_FFFF);
    mem[0] = encode_rtype(7'h01, 3'd0, 5'd12, 5'd9, 5'd10);
    mem[1] = encode_rtype(7'h01, 3'd3, 5'd13, 5'd11, 5'd11);
    start_run();
    finish_run("mext");
`ifdef RTYPE_CORE_MEXT_EN
    rd_reg(12, v); check("mul_x12", v, 32'hFFFF_FFEB);
    rd_reg(13, v); check("mulhu_x13", v, 32'hFFFF_FFFE);
`else
    check("mext_illegal", 32'(illegal), 32'd1);
`endif
    compare_all("mext");

    // Slow memory: core must sit in S_WAIT
    clear_mem();
    mem_delay = 7;
    mem[0] = encode_rtype(7'h00, 3'd4, 5'd14, 5'd9, 5'd11);
    start_run();
    repeat (4) @(negedge clk);
    check("slow_wait", 32'(state), 32'(S_WAIT));
    finish_run("slow");
    compare_all("slow");
    mem_delay = 1;

    // Reset while in S_EXEC drops the writeback
    clear_mem();
    mem[0] = encode_rtype(7'h00, 3'd0, 5'd1, 5'd2, 5'd3);
    start_run();
    for (int c = 0; c < 50 && state != 3'(S_EXEC); c++) @(negedge clk);
    check("exec_reached", 32'(state), 32'(S_EXEC));
    rst = 1'b0;
    @(negedge clk);
    check("exec_rst_state", 32'(state), 32'(S_BREAK));
    rst = 1'b1;
    model_reset();
    compare_all("exec_rst");

    // Random programs
    for (int it = 0; it < 10; it++) begin
      clear_mem();
      for (int r = 1; r < 32; r++)
        dbg_write(r, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 19) == 0) begin
          mem[k] = encode_rtype(7'h20, 3'd1, 5'($urandom), 5'($urandom), 5'($urandom));
        end else begin
          pick = $urandom_range(0, op_f7.size() - 1);
          mem[k] = encode_rtype(op_f7[pick], op_f3[pick], 5'($urandom), 5'($urandom), 5'($urandom));
        end
      end
      mem_delay = $urandom_range(1, 4);
      start_run();
      finish_run($sformatf("rnd%0d", it));
      compare_all($sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
